oled_refresh: RTL and testbench
===============================

OLED_REFRESH -- requirements
Module: oled_refresh

Interface
REQ-001 SHALL have parameter COLS, default 128: display width in pixels (1..256).
REQ-002 SHALL have parameter ROWS, default 128: display height in pixels (1..256).
REQ-003 SHALL define local FB_BYTES = COLS*ROWS*2 (16-bit pixels) and AW = clog2(FB_BYTES).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port init_done  input  1  level from the OLED init sequencer; high = panel configured.
REQ-007 SHALL have port start  input  1  one-cycle frame-refresh request.
REQ-008 SHALL have port fb_data  input  8  framebuffer read data; synchronous RAM, valid one cycle after fb_addr.
REQ-009 SHALL have port fb_addr  output  AW  framebuffer byte address.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-012 SHALL have port oled_cs  output  1  panel chip select, active-low.
REQ-013 SHALL have port oled_e  output  1  panel enable strobe; byte latched on its falling edge.
REQ-014 SHALL have port oled_dc  output  1  0 = command byte, 1 = argument/pixel byte.
REQ-015 SHALL have port oled_dout  output  8  panel data bus.

Function
REQ-016 SHALL implement states IDLE, HDR_LOAD, HDR_LATCH, PIX_LOAD, PIX_LATCH, FINISH; all outputs registered.
REQ-017 SHALL send each byte in two cycles: LOAD (oled_dout/oled_dc driven, oled_e=1), then LATCH (oled_e=0, oled_dout/oled_dc held).
REQ-018 SHALL send header bytes in order, with dc: 0x15/0, 0x00/1, COLS-1/1, 0x75/0, 0x00/1, ROWS-1/1, 0x5C/0, using a 3-bit header index.
REQ-019 SHALL send FB_BYTES pixel bytes after the header, dc=1, oled_dout=fb_data, in fb_addr order 0..FB_BYTES-1.
REQ-020 IDLE: start=1 with init_done=1 -> HDR_LOAD, with oled_cs=0, busy=1, fb_addr=0, header index=0, all next edge.
REQ-021 IDLE: start while init_done=0 SHALL be ignored, not remembered.
REQ-022 HDR_LATCH -> HDR_LOAD while header bytes remain; after byte 7 -> PIX_LOAD.
REQ-023 PIX_LOAD SHALL capture fb_data and increment fb_addr in the same cycle, so the next PIX_LOAD sees data for the new address.
REQ-024 Byte counter SHALL be separate from fb_addr; PIX_LATCH of byte FB_BYTES-1 -> FINISH; fb_addr wraps to 0 after its last increment.
REQ-025 FINISH (one cycle): done=1, oled_cs=1, oled_e=1; next state IDLE, or HDR_LOAD if pending set.
REQ-026 start while busy (any non-IDLE state, incl. FINISH) SHALL set pending; pending is one-deep and cleared when the next frame starts.
REQ-027 A pending frame SHALL start from FINISH as per REQ-020 without an IDLE cycle: cs high exactly one cycle between frames.
REQ-028 busy SHALL be 1 in HDR_*/PIX_* states, 0 in IDLE and FINISH.
REQ-029 init_done falling mid-frame SHALL NOT abort the frame; it only gates new starts.
REQ-030 Frame latency: start accepted at edge k -> done high in cycle k+14+2*FB_BYTES+1.

Reset
REQ-031 rst=1 at a rising edge SHALL force: state=IDLE, oled_cs=1, oled_e=1, oled_dc=0, oled_dout=0x00, fb_addr=0, busy=0, done=0, pending=0.
REQ-032 rst mid-frame SHALL abort at the next edge, with no partial byte completed afterwards and no done pulse.

Verification (COLS=4, ROWS=2, FB_BYTES=16, fb RAM preloaded with byte i = 0xA0+i)
REQ-033 init_done=1, start pulse -> oled_dout/dc seen on e falling: 15/0,00/1,03/1,75/0,00/1,01/1,5C/0, then A0..AF/1; done 1 cycle, 47 cycles after acceptance.
REQ-034 init_done=0, start pulse -> cs stays 1, busy stays 0, no e toggles; later start with init_done=1 -> normal frame.
REQ-035 Second start mid-pixel-stream and third start in the same frame -> exactly one more frame, cs high exactly one cycle between frames, two done pulses total.
REQ-036 rst asserted during pixel byte 5 -> next cycle cs=1, e=1, busy=0, fb_addr=0; no done pulse; new start replays full header.
REQ-037 Checker on all runs: e high exactly one cycle per byte, dout/dc stable across each LOAD/LATCH pair, cs low throughout every frame.

Source files
------------

// File: rtl/oled_refresh.sv
// Streams one frame to a 16-bit-colour OLED panel: a 7-byte window/write header
// followed by every framebuffer byte, each byte strobed out as a LOAD/LATCH pair.
module oled_refresh #(
  parameter int COLS = 128,
  parameter int ROWS = 128,
  localparam int FB_BYTES = COLS * ROWS * 2,
  localparam int AW = $clog2(FB_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_done,
  input  logic          start,
  input  logic [7:0]    fb_data,
  output logic [AW-1:0] fb_addr,
  output logic          busy,
  output logic          done,
  output logic          oled_cs,
  output logic          oled_e,
  output logic          oled_dc,
  output logic [7:0]    oled_dout
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_LOAD,
    HDR_LATCH,
    PIX_LOAD,
    PIX_LATCH,
    FINISH
  } state_t;

  localparam logic [AW-1:0] LAST    = AW'(FB_BYTES - 1);
  localparam logic [7:0]    COL_END = 8'(COLS - 1);
  localparam logic [7:0]    ROW_END = 8'(ROWS - 1);

  state_t        state;
  logic [2:0]    hdr_idx;
  logic [AW-1:0] pix_cnt;
  logic          pending;
  logic [AW-1:0] next_addr;

  // Header entries are {dc, byte}: set column window, set row window, write RAM.
  function automatic logic [8:0] hdr_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    hdr_byte = {1'b0, 8'h15};
      3'd1:    hdr_byte = {1'b1, 8'h00};
      3'd2:    hdr_byte = {1'b1, COL_END};
      3'd3:    hdr_byte = {1'b0, 8'h75};
      3'd4:    hdr_byte = {1'b1, 8'h00};
      3'd5:    hdr_byte = {1'b1, ROW_END};
      default: hdr_byte = {1'b0, 8'h5C};
    endcase
  endfunction

  assign next_addr = (fb_addr == LAST) ? '0 : fb_addr + 1'b1;

  // fb_addr advances as each pixel is loaded, so the synchronous RAM has the
  // following byte ready by the next PIX_LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      oled_cs   <= 1'b1;
      oled_e    <= 1'b1;
      oled_dc   <= 1'b0;
      oled_dout <= 8'h00;
      fb_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pending   <= 1'b0;
      hdr_idx   <= '0;
      pix_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (start && state != IDLE && state != FINISH)
        pending <= 1'b1;
      case (state)
        IDLE, FINISH: begin
          if (init_done && (start || pending)) begin
            state                <= HDR_LOAD;
            oled_cs              <= 1'b0;
            oled_e               <= 1'b1;
            busy                 <= 1'b1;
            fb_addr              <= '0;
            hdr_idx              <= '0;
            pix_cnt              <= '0;
            pending              <= 1'b0;
            {oled_dc, oled_dout} <= hdr_byte(3'd0);
          end else if (state == FINISH) begin
            state   <= IDLE;
            pending <= pending | start;
          end
        end
        HDR_LOAD: begin
          oled_e <= 1'b0;
          state  <= HDR_LATCH;
        end
        HDR_LATCH: begin
          oled_e <= 1'b1;
          if (hdr_idx == 3'd6) begin
            state     <= PIX_LOAD;
            oled_dc   <= 1'b1;
            oled_dout <= fb_data;
            fb_addr   <= next_addr;
          end else begin
            state                <= HDR_LOAD;
            hdr_idx              <= hdr_idx + 3'd1;
            {oled_dc, oled_dout} <= hdr_byte(hdr_idx + 3'd1);
          end
        end
        PIX_LOAD: begin
          oled_e <= 1'b0;
          state  <= PIX_LATCH;
        end
        PIX_LATCH: begin
          oled_e <= 1'b1;
          if (pix_cnt == LAST) begin
            state   <= FINISH;
            done    <= 1'b1;
            oled_cs <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state     <= PIX_LOAD;
            pix_cnt   <= pix_cnt + 1'b1;
            oled_dc   <= 1'b1;
            oled_dout <= fb_data;
            fb_addr   <= next_addr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_refresh.sv
// Bench for oled_refresh on a 4x2 panel: a frame-position reference model checked
// every cycle, plus directed scenarios with hand-computed byte streams and timings.
module tb_oled_refresh;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int FB   = COLS * ROWS * 2;
  localparam int FIN  = 14 + 2 * FB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done = 1'b0;
  logic       start = 1'b0;
  logic [7:0] fb_data;
  logic [3:0] fb_addr;
  logic       busy, done, oled_cs, oled_e, oled_dc;
  logic [7:0] oled_dout;

  oled_refresh #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .start(start),
    .fb_data(fb_data), .fb_addr(fb_addr), .busy(busy), .done(done),
    .oled_cs(oled_cs), .oled_e(oled_e), .oled_dc(oled_dc), .oled_dout(oled_dout)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [FB];
  initial for (int i = 0; i < FB; i++) mem[i] = 8'(8'hA0 + i);
  always @(posedge clk) fb_data <= mem[fb_addr];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("[TB] FAIL %s: actual %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: pos is the cycle offset into the current frame (-1 when idle);
  // every output follows from that offset with plain arithmetic.
  int         pos = -1;
  bit         pend = 1'b0;
  logic [8:0] last_byte = 9'h000;
  logic [8:0] hdr_tab [7] = '{9'h015, 9'h100, 9'h103, 9'h075, 9'h100, 9'h101, 9'h05C};

  function automatic logic [8:0] byte_of(input int p);
    if (p < 14) return hdr_tab[p / 2];
    return {1'b1, mem[(p - 14) / 2]};
  endfunction

  function automatic logic [16:0] expected_vec();
    logic [3:0] addr;
    if (pos < 0)
      return {1'b1, 1'b1, last_byte, 1'b0, 1'b0, 4'd0};
    if (pos == FIN)
      return {1'b1, 1'b1, last_byte, 1'b0, 1'b1, 4'd0};
    addr = (pos < 14) ? 4'd0 : 4'(((pos - 14) / 2 + 1) % FB);
    return {1'b0, 1'b1 ^ 1'(pos % 2), byte_of(pos), 1'b1, 1'b0, addr};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pos = -1;
      pend = 1'b0;
      last_byte = 9'h000;
    end else if (pos < 0 || pos == FIN) begin
      if (init_done && (start || pend)) begin
        pos = 0;
        pend = 1'b0;
      end else if (pos == FIN) begin
        pos = -1;
        pend = pend | start;
      end
    end else begin
      if (start) pend = 1'b1;
      pos++;
    end
    if (pos >= 0 && pos < FIN) last_byte = byte_of(pos);
  end

  bit check_en = 1'b0;
  int cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (check_en)
      checkOutput($sformatf("cycle %0d outputs", cyc),
                  int'({oled_cs, oled_e, oled_dc, oled_dout, busy, done, fb_addr}),
                  int'(expected_vec()));
  end

  // Observation of the panel bus: bytes latched on e falling, done pulses, cs-high gaps.
  logic       prev_e = 1'b1;
  logic [8:0] cap [$];
  int         done_cnt = 0;
  int         cs_run = 0;
  int         last_gap = 0;
  always @(negedge clk) begin
    if (prev_e === 1'b1 && oled_e === 1'b0) cap.push_back({oled_dc, oled_dout});
    prev_e = oled_e;
    if (done === 1'b1) done_cnt++;
    if (oled_cs === 1'b1) cs_run++;
    else begin
      if (cs_run > 0) last_gap = cs_run;
      cs_run = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit s, input bit id, input bit r);
    start = s;
    init_done = id;
    rst = r;
    tick();
  endtask

  task automatic timed_frame(output int lat);
    start = 1'b1;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (n == 1) start = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_stream(input string tag, input int expect_len);
    logic [8:0] exp_hdr [7] = '{9'h015, 9'h100, 9'h103, 9'h075, 9'h100, 9'h101, 9'h05C};
    checkOutput({tag, " byte count"}, cap.size(), expect_len);
    for (int i = 0; i < cap.size() && i < expect_len; i++) begin
      if (i < 7) checkOutput($sformatf("%s header %0d", tag, i), cap[i], exp_hdr[i]);
      else checkOutput($sformatf("%s pixel %0d", tag, i - 7), cap[i], 9'h1A0 + i - 7);
    end
  endtask

  initial begin
    int lat, cs_low, busy_hi;
    repeat (3) tick();
    check_en = 1'b1;
    checkOutput("reset cs", oled_cs, 1);
    checkOutput("reset e", oled_e, 1);
    checkOutput("reset dc", oled_dc, 0);
    checkOutput("reset dout", oled_dout, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset fb_addr", fb_addr, 0);

    applyStimulus(0, 1, 0);
    repeat (2) tick();
    cap.delete();
    done_cnt = 0;
    timed_frame(lat);
    repeat (3) tick();
    checkOutput("frame1 latency", lat, 47);
    checkOutput("frame1 done pulses", done_cnt, 1);
    check_stream("frame1", 7 + FB);

    applyStimulus(0, 0, 0);
    cap.delete();
    done_cnt = 0;
    cs_low = 0;
    busy_hi = 0;
    applyStimulus(1, 0, 0);
    start = 1'b0;
    repeat (10) begin
      tick();
      if (oled_cs !== 1'b1) cs_low++;
      if (busy !== 1'b0) busy_hi++;
    end
    checkOutput("gated start cs low cycles", cs_low, 0);
    checkOutput("gated start busy cycles", busy_hi, 0);
    checkOutput("gated start bytes", cap.size(), 0);
    applyStimulus(0, 1, 0);
    timed_frame(lat);
    repeat (3) tick();
    checkOutput("post-gate latency", lat, 47);
    check_stream("post-gate", 7 + FB);

    repeat (5) tick();
    done_cnt = 0;
    applyStimulus(1, 1, 0);
    start = 1'b0;
    repeat (25) tick();
    applyStimulus(1, 1, 0);
    start = 1'b0;
    repeat (5) tick();
    applyStimulus(1, 1, 0);
    start = 1'b0;
    for (int n = 0; n < 300 && done_cnt < 2; n++) tick();
    repeat (60) tick();
    checkOutput("queued frames done pulses", done_cnt, 2);
    checkOutput("cs gap between frames", last_gap, 1);

    done_cnt = 0;
    cap.delete();
    start = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      tick();
      if (n == 1) start = 1'b0;
    end
    applyStimulus(0, 1, 1);
    checkOutput("abort cs", oled_cs, 1);
    checkOutput("abort e", oled_e, 1);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort fb_addr", fb_addr, 0);
    rst = 1'b0;
    repeat (60) tick();
    checkOutput("abort done pulses", done_cnt, 0);
    checkOutput("abort bytes latched", cap.size(), 12);
    cap.delete();
    timed_frame(lat);
    repeat (3) tick();
    check_stream("after-abort", 7 + FB);

    // Random traffic: sporadic starts, init_done drops and resets.
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 15) == 0) && (pos != FIN);
      if ($urandom_range(0, 79) == 0) init_done = ~init_done;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    applyStimulus(0, 1, 0);
    repeat (5) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
